// File: rtl/cfg_region_router.sv
// Table-driven config-bus router: decodes the region-select field, forwards one
// transaction at a time to the selected slave and returns its response or a bus error.
module cfg_region_router #(
  parameter int                     ADDR_WIDTH     = 16,
  parameter int                     DATA_WIDTH     = 32,
  parameter int                     SEL_LSB        = 12,
  parameter int                     NUM_REGIONS    = 13,
  parameter logic [NUM_REGIONS-1:0] REGION_EN      = '1,
  parameter int                     TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]  ERR_RDATA      = DATA_WIDTH'(32'hBADC_0FFE)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cfg_req_i,
  output logic                              cfg_gnt_o,
  input  logic [ADDR_WIDTH-1:0]             cfg_addr_i,
  input  logic                              cfg_wen_i,
  input  logic [DATA_WIDTH-1:0]             cfg_wdata_i,
  output logic                              cfg_rvalid_o,
  output logic [DATA_WIDTH-1:0]             cfg_rdata_o,
  output logic                              cfg_err_o,
  output logic [NUM_REGIONS-1:0]            slv_req_o,
  output logic [SEL_LSB-1:0]                slv_addr_o,
  output logic                              slv_wen_o,
  output logic [DATA_WIDTH-1:0]             slv_wdata_o,
  input  logic [NUM_REGIONS-1:0]            slv_gnt_i,
  input  logic [NUM_REGIONS-1:0]            slv_rvalid_i,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] slv_rdata_i,
  output logic [7:0]                        err_count_o
);

  localparam int SEL_W = ADDR_WIDTH - SEL_LSB;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_t;

  state_t                state;
  logic [SEL_W-1:0]      sel;
  logic [SEL_LSB-1:0]    off;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic [CNT_W-1:0]      cnt;
  logic [7:0]            err_count;

  logic [SEL_W-1:0]       sel_in;
  logic                   mapped;
  logic                   gnt_s;
  logic                   rvalid_s;
  logic [DATA_WIDTH-1:0]  rdata_s;
  logic [NUM_REGIONS-1:0] req_vec;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   timeout;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sel_in  = cfg_addr_i[ADDR_WIDTH-1:SEL_LSB];
  assign cnt_nxt = cnt + CNT_W'(1);
  // Compare against the incremented count so the error response lands TIMEOUT_CYCLES+1 after accept
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_nxt == TO_LIM);

  // Region decode for the incoming address and strobe filtering for the latched region
  always_comb begin
    mapped   = 1'b0;
    gnt_s    = 1'b0;
    rvalid_s = 1'b0;
    rdata_s  = '0;
    req_vec  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_in == SEL_W'(i)) mapped = REGION_EN[i];
      if (sel == SEL_W'(i)) begin
        gnt_s      = slv_gnt_i[i];
        rvalid_s   = slv_rvalid_i[i];
        rdata_s    = slv_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        req_vec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      err       <= 1'b0;
      cnt       <= '0;
      err_count <= '0;
    end else begin
      if (state == RESP && err) err_count <= sat_inc8(err_count);
      case (state)
        IDLE: begin
          if (cfg_req_i) begin
            cnt   <= '0;
            err   <= !mapped;
            state <= mapped ? FWD : RESP;
          end
        end
        FWD: begin
          cnt <= cnt_nxt;
          if (timeout) begin
            err   <= 1'b1;
            state <= RESP;
          end else if (gnt_s) begin
            state <= rvalid_s ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (timeout) begin
            err   <= 1'b1;
            state <= RESP;
          end else if (rvalid_s) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Payload and response data registers; outputs are gated by state, so no reset needed
  always_ff @(posedge clk_i) begin
    if (state == IDLE && cfg_req_i) begin
      sel   <= sel_in;
      off   <= cfg_addr_i[SEL_LSB-1:0];
      wen   <= cfg_wen_i;
      wdata <= cfg_wdata_i;
    end
    if ((state == FWD && gnt_s && rvalid_s) || (state == WAIT && rvalid_s)) rdata <= rdata_s;
  end

  assign cfg_gnt_o    = (state == IDLE);
  assign slv_req_o    = (state == FWD) ? req_vec : '0;
  assign slv_addr_o   = (state == FWD) ? off : '0;
  assign slv_wen_o    = (state == FWD) && wen;
  assign slv_wdata_o  = (state == FWD) ? wdata : '0;
  assign cfg_rvalid_o = (state == RESP);
  assign cfg_err_o    = (state == RESP) && err;
  assign cfg_rdata_o  = (state != RESP) ? '0 : (err ? ERR_RDATA : rdata);
  assign err_count_o  = err_count;

endmodule

// File: tb/tb_cfg_region_router.sv
// Directed bench for cfg_region_router: vector table of single transactions plus
// a hand-written mid-transaction reset sequence.
module tb_cfg_region_router;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SL = 12;
  localparam int NR = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_req = 1'b0;
  logic              cfg_gnt;
  logic [AW-1:0]     cfg_addr = '0;
  logic              cfg_wen = 1'b0;
  logic [DW-1:0]     cfg_wdata = '0;
  logic              cfg_rvalid;
  logic [DW-1:0]     cfg_rdata;
  logic              cfg_err;
  logic [NR-1:0]     slv_req;
  logic [SL-1:0]     slv_addr;
  logic              slv_wen;
  logic [DW-1:0]     slv_wdata;
  logic [NR-1:0]     slv_gnt = '0;
  logic [NR-1:0]     slv_rvalid = '0;
  logic [NR*DW-1:0]  slv_rdata = '0;
  logic [7:0]        err_count;

  always #5 clk = ~clk;

  cfg_region_router #(
    .TIMEOUT_CYCLES(8),
    .REGION_EN     (13'h1FDF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_req_i   (cfg_req),
    .cfg_gnt_o   (cfg_gnt),
    .cfg_addr_i  (cfg_addr),
    .cfg_wen_i   (cfg_wen),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o (cfg_rdata),
    .cfg_err_o   (cfg_err),
    .slv_req_o   (slv_req),
    .slv_addr_o  (slv_addr),
    .slv_wen_o   (slv_wen),
    .slv_wdata_o (slv_wdata),
    .slv_gnt_i   (slv_gnt),
    .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i (slv_rdata),
    .err_count_o (err_count)
  );

  typedef struct {
    logic [15:0] addr;
    logic        wen;
    logic [31:0] wdata;
    int          gcyc;
    int          rcyc;
    logic [31:0] srdata;
    logic [12:0] noise;
    int          lat;
    int          req_last;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   exp_ec = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_slaves(input vec_t v, input logic [12:0] oh, input int c);
    slv_gnt    = v.noise | ((v.gcyc != 0 && c == v.gcyc) ? oh : 13'h0);
    slv_rvalid = v.noise | ((v.rcyc != 0 && c == v.rcyc) ? oh : 13'h0);
    for (int i = 0; i < NR; i++)
      slv_rdata[i*DW +: DW] = oh[i] ? v.srdata : (32'hEE00_0000 | 32'(i));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          sel;
    logic [12:0] oh;
    string       tag;
    sel = int'(v.addr[15:12]);
    oh  = (sel < NR) ? (13'h1 << sel) : 13'h0;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    cfg_req   = 1'b1;
    cfg_addr  = v.addr;
    cfg_wen   = v.wen;
    cfg_wdata = v.wdata;
    drive_slaves(v, oh, 0);
    @(negedge clk);
    check({tag, " gnt_idle"}, 32'(cfg_gnt), 32'd1);
    check({tag, " err_count"}, 32'(err_count), 32'(exp_ec));
    for (int c = 1; c <= v.lat; c++) begin
      @(posedge clk); #1;
      cfg_req = 1'b0;
      drive_slaves(v, oh, c);
      @(negedge clk);
      check($sformatf("%s c%0d rvalid", tag, c), 32'(cfg_rvalid), 32'(c == v.lat));
      check($sformatf("%s c%0d gnt_busy", tag, c), 32'(cfg_gnt), 32'd0);
      check($sformatf("%s c%0d slv_req", tag, c), 32'(slv_req), 32'((c <= v.req_last) ? oh : 13'h0));
      if (c <= v.req_last) begin
        check($sformatf("%s c%0d slv_addr", tag, c), 32'(slv_addr), 32'(v.addr[11:0]));
        check($sformatf("%s c%0d slv_wen", tag, c), 32'(slv_wen), 32'(v.wen));
        check($sformatf("%s c%0d slv_wdata", tag, c), slv_wdata, v.wdata);
      end
      if (c == v.lat) begin
        check({tag, " rdata"}, cfg_rdata, v.exp_rdata);
        check({tag, " err"}, 32'(cfg_err), 32'(v.exp_err));
      end else begin
        check($sformatf("%s c%0d rdata_idle", tag, c), cfg_rdata, 32'h0);
        check($sformatf("%s c%0d err_idle", tag, c), 32'(cfg_err), 32'd0);
      end
    end
    if (v.exp_err && exp_ec < 255) exp_ec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr:16'h1008, wen:1'b0, wdata:32'h0, gcyc:1, rcyc:2, srdata:32'h1234_5678,
                noise:13'h0, lat:3, req_last:1, exp_err:1'b0, exp_rdata:32'h1234_5678};
    vecs[1] = '{addr:16'hA100, wen:1'b1, wdata:32'h0000_CAFE, gcyc:5, rcyc:6, srdata:32'h5555_AAAA,
                noise:13'h0, lat:7, req_last:5, exp_err:1'b0, exp_rdata:32'h5555_AAAA};
    vecs[2] = '{addr:16'hD000, wen:1'b0, wdata:32'h0, gcyc:0, rcyc:0, srdata:32'h0,
                noise:13'h0, lat:1, req_last:0, exp_err:1'b1, exp_rdata:32'hBADC_0FFE};
    vecs[3] = '{addr:16'h5000, wen:1'b0, wdata:32'h0, gcyc:1, rcyc:1, srdata:32'h1111_2222,
                noise:13'h0, lat:1, req_last:0, exp_err:1'b1, exp_rdata:32'hBADC_0FFE};
    vecs[4] = '{addr:16'h3FFC, wen:1'b0, wdata:32'h0, gcyc:1, rcyc:1, srdata:32'hDEAD_BEEF,
                noise:13'h0010, lat:2, req_last:1, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF};
    vecs[5] = '{addr:16'h2010, wen:1'b0, wdata:32'h0, gcyc:1, rcyc:0, srdata:32'h7777_7777,
                noise:13'h0, lat:9, req_last:1, exp_err:1'b1, exp_rdata:32'hBADC_0FFE};
    vecs[6] = '{addr:16'h0004, wen:1'b0, wdata:32'h0, gcyc:1, rcyc:3, srdata:32'h600D_0000,
                noise:13'h0004, lat:4, req_last:1, exp_err:1'b0, exp_rdata:32'h600D_0000};
    vecs[7] = '{addr:16'hC7FF, wen:1'b1, wdata:32'h1357_9BDF, gcyc:8, rcyc:8, srdata:32'h2468_ACE0,
                noise:13'h0, lat:9, req_last:8, exp_err:1'b1, exp_rdata:32'hBADC_0FFE};

    #1;
    check("rst gnt", 32'(cfg_gnt), 32'd1);
    check("rst rvalid", 32'(cfg_rvalid), 32'd0);
    check("rst rdata", cfg_rdata, 32'h0);
    check("rst err", 32'(cfg_err), 32'd0);
    check("rst slv_req", 32'(slv_req), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    @(posedge clk); #1;
    slv_gnt = '0;
    slv_rvalid = '0;
    @(negedge clk);
    check("final err_count", 32'(err_count), 32'(exp_ec));

    // Reset while waiting for slave 3's response
    @(posedge clk); #1;
    cfg_req  = 1'b1;
    cfg_addr = 16'h3000;
    cfg_wen  = 1'b0;
    @(negedge clk);
    check("mrst accept gnt", 32'(cfg_gnt), 32'd1);
    @(posedge clk); #1;
    cfg_req = 1'b0;
    slv_gnt = 13'h0008;
    @(negedge clk);
    check("mrst fwd slv_req", 32'(slv_req), 32'h0008);
    @(posedge clk); #1;
    slv_gnt = '0;
    @(negedge clk);
    check("mrst wait slv_req", 32'(slv_req), 32'd0);
    check("mrst wait gnt", 32'(cfg_gnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp_ec = 0;
    check("mrst gnt", 32'(cfg_gnt), 32'd1);
    check("mrst slv_req", 32'(slv_req), 32'd0);
    check("mrst slv_addr", 32'(slv_addr), 32'd0);
    check("mrst slv_wdata", slv_wdata, 32'h0);
    check("mrst rvalid", 32'(cfg_rvalid), 32'd0);
    check("mrst rdata", cfg_rdata, 32'h0);
    check("mrst err_count", 32'(err_count), 32'd0);
    slv_rvalid = 13'h0008;
    slv_rdata[3*DW +: DW] = 32'hFEED_F00D;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mrst no_resp k%0d", k), 32'(cfg_rvalid), 32'd0);
      check($sformatf("mrst idle_gnt k%0d", k), 32'(cfg_gnt), 32'd1);
      @(posedge clk); #1;
      slv_rvalid = '0;
    end
    run_vec(vecs[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_region_router.md
# cfg_region_router

Parametrised configuration-bus router for the HD-accelerator config unit. It takes single transactions from the upstream config master, decodes the region-select field of the address into one of `NUM_REGIONS` slave ports, and forwards each transaction with a local offset. It returns the slave's response upstream. Unmapped or disabled regions and unresponsive slaves produce a bus-error response instead of a hang. It replaces fixed per-block address compares with one table-driven router, with one transaction outstanding.

## Interface
- `ADDR_WIDTH`, 16: upstream config address width.
- `DATA_WIDTH`, 32: data width.
- `SEL_LSB`, 12: LSB of the region-select field. Field is `[ADDR_WIDTH-1:SEL_LSB]`; the local offset is `[SEL_LSB-1:0]`.
- `NUM_REGIONS`, 13: number of slave ports. Must be ≤ 2^(`ADDR_WIDTH`-`SEL_LSB`).
- `REGION_EN`, all ones (`NUM_REGIONS` bits): bit i = 1 means region i is mapped.
- `TIMEOUT_CYCLES`, 255: abort limit, in cycles. 0 disables the timeout.
- `ERR_RDATA`, 32'hBADC_0FFE: read data returned with every error response.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `cfg_req_i` in 1: upstream request.
- `cfg_gnt_o` out 1: upstream grant. A request is accepted when `cfg_req_i` && `cfg_gnt_o`.
- `cfg_addr_i` in `ADDR_WIDTH`: byte address.
- `cfg_wen_i` in 1: 1 = write, 0 = read.
- `cfg_wdata_i` in `DATA_WIDTH`: write data.
- `cfg_rvalid_o` out 1: response strobe, one cycle wide.
- `cfg_rdata_o` out `DATA_WIDTH`: response data.
- `cfg_err_o` out 1: bus error, valid together with `cfg_rvalid_o`.
- `slv_req_o` out `NUM_REGIONS`: one-hot request to the slaves.
- `slv_addr_o` out `SEL_LSB`: local offset.
- `slv_wen_o` out 1: write enable to the slaves.
- `slv_wdata_o` out `DATA_WIDTH`: write data to the slaves.
- `slv_gnt_i` in `NUM_REGIONS`: per-slave grant.
- `slv_rvalid_i` in `NUM_REGIONS`: per-slave response strobe.
- `slv_rdata_i` in `NUM_REGIONS` × `DATA_WIDTH`: per-slave response data, packed.
- `err_count_o` out 8: number of error responses issued, saturating.

## Operation
- Reset values:
  - state `IDLE`
  - `cfg_gnt_o`=1 (combinational from `IDLE`)
  - all other outputs 0, including `err_count_o`=0
- FSM states: `IDLE`, `FWD`, `WAIT`, `RESP`.
- `IDLE`:
  - `cfg_gnt_o`=1.
  - On accept, register addr, wen, wdata and region index `sel = addr[ADDR_WIDTH-1:SEL_LSB]`.
  - If `sel` < `NUM_REGIONS` and `REGION_EN[sel]`=1: go to `FWD`.
  - Otherwise: latch `err`=1 and go to `RESP`.
- `FWD`:
  - `slv_req_o[sel]`=1; `slv_addr_o`, `slv_wen_o`, `slv_wdata_o` driven from the registers.
  - Payload stays stable until `slv_gnt_i[sel]`=1; then go to `WAIT`.
  - If `slv_gnt_i[sel]` and `slv_rvalid_i[sel]` are both high in the same cycle, capture the response and go straight to `RESP`.
- `WAIT`:
  - `slv_req_o`=0.
  - On `slv_rvalid_i[sel]`, capture `slv_rdata_i[sel]` and set `err`=0; go to `RESP`.
  - Writes also complete only on `rvalid`; rdata is don't-care but is still forwarded.
- `RESP`:
  - `cfg_rvalid_o`=1 for exactly one cycle, with `cfg_rdata_o` = captured data (or `ERR_RDATA` if `err`) and `cfg_err_o`=`err`.
  - Go to `IDLE`.
  - Upstream cannot back-pressure responses.
  - `cfg_rdata_o` and `cfg_err_o` return to 0 when `cfg_rvalid_o` is 0.
- Timeout:
  - A counter clears on accept and increments every cycle in `FWD` or `WAIT`.
  - If `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES`, drop `slv_req_o`, set `err`=1 and go to `RESP`.
  - Timeout takes priority over a grant or rvalid arriving in the same cycle.
- Strobe filtering:
  - `slv_rvalid_i` and `slv_gnt_i` from a non-selected slave are ignored.
  - Strobes arriving in any state other than `FWD`/`WAIT` are ignored. A late response after a timeout is therefore dropped.
- `err_count_o` increments in every `RESP` cycle with `err`=1 and saturates at 255.
- Asserting `rst_i` mid-transaction aborts it: no response is issued and all outputs go to their reset values immediately.

## Timing
- Mapped access, slave granting immediately and responding one cycle later:
  - accept in cycle 0
  - `slv_req_o` in cycle 1 (gnt)
  - `rvalid` in cycle 2
  - `cfg_rvalid_o` in cycle 3
  - Minimum latency: 2 cycles (gnt and rvalid together in cycle 1 gives `cfg_rvalid_o` in cycle 2).
- Unmapped or disabled region: `cfg_rvalid_o`+`cfg_err_o` in cycle 1.
- Timeout: error response in cycle `TIMEOUT_CYCLES`+1 after accept.
- Back-to-back: the next accept is possible in the cycle after `RESP`.
- Throughput is one transaction per ≥3 cycles (≥2 for an unmapped region).

## Test plan
- Read 0x1008, slave 1 grants in cycle 1 and returns 0x1234_5678 in cycle 2:
  - `slv_addr_o`=0x008 with `slv_req_o`=0x0002 only.
  - `cfg_rvalid_o` in cycle 3 with rdata 0x1234_5678 and err=0.
- Write 0xA100 with wdata 0xCAFE, slave 10 holds gnt low for 4 cycles:
  - `slv_req_o[10]`, addr 0x100, wen and wdata stay stable through the stall.
  - Response with err=0.
- Read 0xD000 (`sel`=13 ≥ 13):
  - `cfg_rvalid_o` in cycle 1 with err=1 and rdata 0xBADC_0FFE; no `slv_req_o`.
  - `err_count_o`=1.
- `REGION_EN` bit 5 cleared, access to 0x5000:
  - Error response; slave 5 never requested.
- `TIMEOUT_CYCLES`=8, slave 2 never responds:
  - Error in cycle 9.
  - Slave 2's `rvalid` in cycle 12 is ignored while a new read to region 0 completes normally.
- Assert `rst_i` in `WAIT`:
  - All outputs 0, `cfg_gnt_o`=1.
  - No response is emitted; the next transaction completes normally.
